// File: rtl/control_subcmd_readarea.sv
// rtl/control_subcmd_readarea.sv - walks a clipped framebuffer rectangle with byte reads
// and streams the returned bytes over a valid/ready port through a 2-entry FIFO.
module control_subcmd_readarea #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXEL_HEIGHT    = 5,
  parameter int PIXEL_WIDTH     = 6,
  parameter int _UNUSED         = 0,
  localparam int CB = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1,
  localparam int RB = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1,
  localparam int PB = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
  localparam int DB = 8 + 0 * _UNUSED
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          ack,
  input  logic [CB-1:0] x1,
  input  logic [CB-1:0] width,
  input  logic [RB-1:0] y1,
  input  logic [RB-1:0] height,
  output logic [RB-1:0] row,
  output logic [CB-1:0] column,
  output logic [PB-1:0] pixel,
  output logic          ram_read_enable,
  output logic          ram_access_start,
  input  logic [DB-1:0] ram_data,
  output logic [DB-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done
);

  localparam logic [CB:0]   COL_LIMIT = (CB+1)'(PIXEL_WIDTH);
  localparam logic [RB:0]   ROW_LIMIT = (RB+1)'(PIXEL_HEIGHT);
  localparam logic [PB-1:0] PIX_TOP   = PB'(BYTES_PER_PIXEL - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t state, state_next;

  logic [CB:0]   col_sum, col_end;
  logic [RB:0]   row_sum, row_end;
  logic          area_empty;
  logic [CB-1:0] x_lo, col_hi;
  logic [RB-1:0] y_lo;
  logic          first_read, pending, issue, accept, abort, last_addr;
  logic [1:0]    count, count_next;
  logic [2:0]    fill_after;
  logic [DB-1:0] slot1;

  // One extra bit on the sums so x1+width never wraps before clipping.
  assign col_sum = {1'b0, x1} + {1'b0, width};
  assign row_sum = {1'b0, y1} + {1'b0, height};
  assign col_end = (col_sum > COL_LIMIT) ? COL_LIMIT : col_sum;
  assign row_end = (row_sum > ROW_LIMIT) ? ROW_LIMIT : row_sum;
  assign area_empty = (width == '0) || (height == '0) ||
                      ({1'b0, x1} >= COL_LIMIT) || ({1'b0, y1} >= ROW_LIMIT);

  assign accept     = out_valid && out_ready;
  assign abort      = (state != S_IDLE) && !enable;
  assign last_addr  = (pixel == '0) && (column == x_lo) && (row == y_lo);
  // Occupancy after this cycle's accept and capture; also the next FIFO count.
  assign fill_after = {1'b0, count} - {2'b0, accept} + {2'b0, pending};
  assign count_next = abort ? 2'd0 : fill_after[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      S_IDLE: if (enable) state_next = area_empty ? S_DONE : S_READ;
      S_READ: begin
        if (!enable) state_next = S_IDLE;
        else begin
          issue = (fill_after < 3'd2);
          if (issue && last_addr) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!enable)                 state_next = S_IDLE;
        else if (fill_after == 3'd0) state_next = S_DONE;
      end
      S_DONE:  if (!enable || ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign ram_read_enable  = issue;
  assign ram_access_start = issue && first_read;
  assign done             = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      slot1     <= '0;
      pending   <= 1'b0;
    end else begin
      count     <= count_next;
      out_valid <= (count_next != 2'd0);
      pending   <= issue;
      if (!abort) begin
        if (accept) begin
          if (pending && count == 2'd1) out_data <= ram_data;
          else                          out_data <= slot1;
          if (pending) slot1 <= ram_data;
        end else if (pending) begin
          if (count == 2'd0) out_data <= ram_data;
          else               slot1    <= ram_data;
        end
      end
    end
  end

  // The final address is held after the last read so it never leaves the area.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row        <= '0;
      column     <= '0;
      pixel      <= '0;
      x_lo       <= '0;
      y_lo       <= '0;
      col_hi     <= '0;
      first_read <= 1'b0;
    end else if (state == S_IDLE && enable && !area_empty) begin
      row        <= RB'(row_end - 1'b1);
      column     <= CB'(col_end - 1'b1);
      pixel      <= PIX_TOP;
      x_lo       <= x1;
      y_lo       <= y1;
      col_hi     <= CB'(col_end - 1'b1);
      first_read <= 1'b1;
    end else if (issue) begin
      first_read <= 1'b0;
      if (!last_addr) begin
        if (pixel != '0) pixel <= pixel - 1'b1;
        else begin
          pixel <= PIX_TOP;
          if (column != x_lo) column <= column - 1'b1;
          else begin
            column <= col_hi;
            row    <= row - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_control_subcmd_readarea.sv
// tb/tb_control_subcmd_readarea.sv - scoreboard bench for control_subcmd_readarea
module tb_control_subcmd_readarea;
  localparam int W = 6, H = 5, BPP = 2;

  logic       clk = 1'b0;
  logic       reset, enable, ack, out_ready;
  logic [2:0] x1, width, y1, height, row, column;
  logic [0:0] pixel;
  logic       ram_read_enable, ram_access_start, out_valid, done;
  logic [7:0] ram_data = 8'h00;
  logic [7:0] out_data;

  int checks = 0, passes = 0;
  int exp_q[$];
  int addr_q[$];
  int r_acc, r_done_cyc, r_first_rd, r_first_acc, r_last_acc, r_max_out, r_reads, r_nexp;

  control_subcmd_readarea #(.BYTES_PER_PIXEL(BPP), .PIXEL_HEIGHT(H), .PIXEL_WIDTH(W), ._UNUSED(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ack(ack),
    .x1(x1), .width(width), .y1(y1), .height(height),
    .row(row), .column(column), .pixel(pixel),
    .ram_read_enable(ram_read_enable), .ram_access_start(ram_access_start),
    .ram_data(ram_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int hash(int r, int c, int p);
    return ((r * 53) ^ (c * 17) ^ (p * 101) ^ 195) & 255;
  endfunction

  // Synchronous RAM model: data appears the cycle after the read strobe.
  always @(posedge clk) if (ram_read_enable === 1'b1) ram_data <= 8'(hash(int'(row), int'(column), int'(pixel)));

  task automatic push_area(input int xv, input int yv, input int wv, input int hv);
    int ce, re;
    exp_q.delete();
    addr_q.delete();
    ce = (xv + wv > W) ? W : xv + wv;
    re = (yv + hv > H) ? H : yv + hv;
    if (wv > 0 && hv > 0 && xv < W && yv < H)
      for (int r = re - 1; r >= yv; r--)
        for (int c = ce - 1; c >= xv; c--)
          for (int p = BPP - 1; p >= 0; p--) begin
            exp_q.push_back(hash(r, c, p));
            addr_q.push_back(r * 256 + c * 16 + p);
          end
    r_nexp = exp_q.size();
  endtask

  task automatic run_cmd(input int xv, input int yv, input int wv, input int hv,
                         input int ready_pct, input int abort_after, input int budget);
    int outstanding, cyc, a, e;
    logic held;
    logic [7:0] held_data;
    push_area(xv, yv, wv, hv);
    r_acc = 0; r_reads = 0; r_first_rd = -1; r_first_acc = -1; r_last_acc = -1;
    r_max_out = 0; r_done_cyc = -1;
    outstanding = 0; held = 1'b0; held_data = 8'h00; cyc = 0;
    @(negedge clk);
    x1 = 3'(xv); y1 = 3'(yv); width = 3'(wv); height = 3'(hv);
    enable = 1'b1; ack = 1'b0;
    while (cyc < budget) begin
      if (abort_after >= 0 && r_acc == abort_after) break;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data)
          $display("FAIL hold_stable cyc=%0d got valid=%b data=%h want valid=1 data=%h", cyc, out_valid, out_data, held_data);
        else passes++;
      end
      if (ram_read_enable === 1'b1) begin
        a = int'(row) * 256 + int'(column) * 16 + int'(pixel);
        e = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
        checks++;
        if (a !== e) $display("FAIL read_addr cyc=%0d got %h want %h", cyc, a, e);
        else passes++;
        checks++;
        if (ram_access_start !== (r_reads == 0))
          $display("FAIL access_start read#%0d got %b want %b", r_reads, ram_access_start, (r_reads == 0));
        else passes++;
        if (r_first_rd < 0) r_first_rd = cyc;
        r_reads++;
        outstanding++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (int'(out_data) !== e) $display("FAIL out_data byte#%0d got %h want %h", r_acc, out_data, e);
        else passes++;
        if (r_first_acc < 0) r_first_acc = cyc;
        r_last_acc = cyc;
        r_acc++;
        outstanding--;
      end
      if (outstanding > r_max_out) r_max_out = outstanding;
      held = out_valid && !out_ready;
      held_data = out_data;
      if (done === 1'b1) begin
        r_done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (abort_after >= 0) return;
    checks++;
    if (r_done_cyc < 0) $display("FAIL timeout got no done in %0d cycles want done", budget);
    else passes++;
    checks++;
    if (r_acc !== r_nexp) $display("FAIL byte_count got %0d want %0d", r_acc, r_nexp);
    else passes++;
    checks++;
    if (r_max_out > 2) $display("FAIL occupancy got %0d want <=2", r_max_out);
    else passes++;
    if (r_nexp > 0) begin
      checks++;
      if (r_done_cyc !== r_last_acc + 1) $display("FAIL done_timing got cyc %0d want %0d", r_done_cyc, r_last_acc + 1);
      else passes++;
    end
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0) $display("FAIL done_hold got done=%b valid=%b want 1/0", done, out_valid);
      else passes++;
    end
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0) $display("FAIL ack_idle got done=%b want 0", done);
    else passes++;
    ack = 1'b0;
    enable = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || ram_read_enable !== 1'b0) $display("FAIL stay_idle got done=%b rd=%b want 0/0", done, ram_read_enable);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; ack = 1'b0; out_ready = 1'b0;
    x1 = '0; y1 = '0; width = '0; height = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({row, column, pixel, out_data, out_valid, ram_read_enable, ram_access_start, done} !== 22'd0)
      $display("FAIL reset_state got %h want 0", {row, column, pixel, out_data, out_valid, ram_read_enable, ram_access_start, done});
    else passes++;
    reset = 1'b1;
  endtask

  task automatic test_full_frame();
    run_cmd(0, 0, W, H, 100, -1, 400);
    checks++;
    if (r_last_acc - r_first_acc !== W * H * BPP - 1)
      $display("FAIL throughput got span %0d want %0d", r_last_acc - r_first_acc, W * H * BPP - 1);
    else passes++;
    checks++;
    if (r_first_acc - r_first_rd !== 2) $display("FAIL read_latency got %0d want 2", r_first_acc - r_first_rd);
    else passes++;
  endtask

  task automatic test_backpressure();
    run_cmd(0, 0, W, H, 50, -1, 2000);
  endtask

  task automatic test_subarea();
    run_cmd(2, 1, 3, 2, 100, -1, 200);
    checks++;
    if (r_reads !== 6 * BPP) $display("FAIL subarea_reads got %0d want %0d", r_reads, 6 * BPP);
    else passes++;
  endtask

  task automatic test_clip_edge();
    run_cmd(W - 1, 0, 4, 1, 100, -1, 200);
    checks++;
    if (int'(column) !== W - 1 || r_reads !== BPP) $display("FAIL clip_edge got column=%0d reads=%0d want %0d/%0d", column, r_reads, W - 1, BPP);
    else passes++;
  endtask

  task automatic test_empty();
    run_cmd(1, 1, 0, 2, 100, -1, 20);
    checks++;
    if (r_done_cyc < 0 || r_done_cyc > 2 || r_reads !== 0) $display("FAIL empty_width got done_cyc=%0d reads=%0d want <=2/0", r_done_cyc, r_reads);
    else passes++;
    run_cmd(W, 0, 1, 1, 100, -1, 20);
    checks++;
    if (r_reads !== 0) $display("FAIL empty_x1 got reads=%0d want 0", r_reads);
    else passes++;
  endtask

  task automatic test_abort();
    run_cmd(0, 0, W, H, 100, 5, 200);
    enable = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || ram_read_enable !== 1'b0)
      $display("FAIL abort got valid=%b done=%b rd=%b want 0/0/0", out_valid, done, ram_read_enable);
    else passes++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    x1 = 3'd0; y1 = 3'd0; width = 3'(W); height = 3'(H);
    out_ready = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) $display("FAIL pre_reset_valid got %b want 1", out_valid);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if ({row, column, pixel, out_data, out_valid, ram_read_enable, ram_access_start, done} !== 22'd0)
      $display("FAIL reset_mid got %h want 0", {row, column, pixel, out_data, out_valid, ram_read_enable, ram_access_start, done});
    else passes++;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_subarea();
    test_clip_edge();
    test_empty();
    test_abort();
    test_subarea();
    test_reset_mid();
    test_subarea();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish within 1ms");
    $fatal(1);
  end

endmodule
